// File: rtl/mem_responder.sv
//------------------------------------------------------------------------------
// Module   : mem_responder
// Brief    : On-chip-array stand-in for the SDRAM controller on the processor
//            memory interface, with programmable read/write latency.
//            Optional refresh-stall emulation when REFRESH_STALL_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_responder #(
    parameter int ADDR_WIDTH       = 25,
    parameter int DATA_WIDTH       = 16,
    parameter int DEPTH_WORDS      = 1024,
    parameter int READ_LATENCY     = 4,
    parameter int WRITE_LATENCY    = 2,
    parameter int REFRESH_INTERVAL = 1040,
    parameter int REFRESH_CYCLES   = 8
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  we_i,
    input  logic                  re_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  ack_o,
    output logic                  busy_o
);

    localparam int IDX_W   = $clog2(DEPTH_WORDS);
    localparam int LAT_MAX = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    localparam logic [CNT_W-1:0] c_RD_LOAD = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] c_WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ACCESS  = 2'd1;
    localparam logic [1:0] c_ACK     = 2'd2;
`ifdef REFRESH_STALL_EN
    localparam logic [1:0] c_REFRESH = 2'd3;
`endif

    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_lat_cnt;
    logic [CNT_W-1:0] w_lat_cnt_nxt;
    logic [IDX_W-1:0] r_idx;
    logic             r_is_read;
    logic [IDX_W-1:0] w_idx;
    logic             w_accept;
    logic             w_pend;
    logic             w_unused;

    assign w_idx    = addr_i[IDX_W-1:0];
    assign w_accept = (r_state == c_IDLE) && (we_i || re_i);

`ifdef REFRESH_STALL_EN
    localparam int RI_W = $clog2(REFRESH_INTERVAL + 1);
    localparam int RC_W = $clog2(REFRESH_CYCLES + 1);

    logic [RI_W-1:0] r_ref_cnt;
    logic [RC_W-1:0] r_ref_left;
    logic            r_pend;

    assign w_pend   = r_pend;
    assign w_unused = ^addr_i[ADDR_WIDTH-1:IDX_W];

    // Free-running interval timer; pending is only cleared once the stall has run.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_ref_cnt  <= '0;
            r_ref_left <= '0;
            r_pend     <= 1'b0;
        end else begin
            if (r_ref_cnt == RI_W'(REFRESH_INTERVAL - 1)) begin
                r_ref_cnt <= '0;
                r_pend    <= 1'b1;
            end else begin
                r_ref_cnt <= r_ref_cnt + RI_W'(1);
                if ((r_state == c_REFRESH) && (w_state_nxt == c_IDLE)) begin
                    r_pend <= 1'b0;
                end
            end

            if ((r_state != c_REFRESH) && (w_state_nxt == c_REFRESH)) begin
                r_ref_left <= RC_W'(REFRESH_CYCLES - 1);
            end else if (r_state == c_REFRESH) begin
                r_ref_left <= r_ref_left - RC_W'(1);
            end
        end
    end
`else
    assign w_pend   = 1'b0;
    assign w_unused = ^{addr_i[ADDR_WIDTH-1:IDX_W],
                        (REFRESH_INTERVAL != 0), (REFRESH_CYCLES != 0), w_pend};
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_lat_cnt_nxt = r_lat_cnt;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_nxt   = c_ACCESS;
                    w_lat_cnt_nxt = we_i ? c_WR_LOAD : c_RD_LOAD;
                end
`ifdef REFRESH_STALL_EN
                else if (r_pend) begin
                    w_state_nxt = c_REFRESH;
                end
`endif
            end
            c_ACCESS: begin
                if (r_lat_cnt == '0) begin
                    w_state_nxt = c_ACK;
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt - CNT_W'(1);
                end
            end
            c_ACK: begin
`ifdef REFRESH_STALL_EN
                w_state_nxt = r_pend ? c_REFRESH : c_IDLE;
`else
                w_state_nxt = c_IDLE;
`endif
            end
`ifdef REFRESH_STALL_EN
            c_REFRESH: begin
                if (r_ref_left == '0) begin
                    w_state_nxt = c_IDLE;
                end
            end
`endif
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state   <= c_IDLE;
            r_lat_cnt <= '0;
            r_idx     <= '0;
            r_is_read <= 1'b0;
            ack_o     <= 1'b0;
            busy_o    <= 1'b0;
            data_o    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lat_cnt <= w_lat_cnt_nxt;
            ack_o     <= (w_state_nxt == c_ACK);
            busy_o    <= (w_state_nxt != c_IDLE);
            if (w_accept) begin
                r_idx     <= w_idx;
                r_is_read <= ~we_i;
            end
            if ((r_state == c_ACCESS) && (w_state_nxt == c_ACK) && r_is_read) begin
                data_o <= r_mem[r_idx];
            end
        end
    end

    // Writes commit at the accept edge, so a later reset cannot undo them.
    always_ff @(posedge sys_clk) begin
        if (sys_rst_n && w_accept && we_i) begin
            r_mem[w_idx] <= data_i;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_responder
// Brief    : Directed self-checking bench for mem_responder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [24:0] addr;
    logic [15:0] wdata;
    logic        we;
    logic        re;
    logic [15:0] rdata;
    logic        ack;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_responder #(
        .ADDR_WIDTH       (25),
        .DATA_WIDTH       (16),
        .DEPTH_WORDS      (1024),
        .READ_LATENCY     (4),
        .WRITE_LATENCY    (2),
        .REFRESH_INTERVAL (100),
        .REFRESH_CYCLES   (8)
    ) u_dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .addr_i    (addr),
        .data_i    (wdata),
        .we_i      (we),
        .re_i      (re),
        .data_o    (rdata),
        .ack_o     (ack),
        .busy_o    (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Waits out one refresh stall so the next ~90 cycles are stall-free.
    task automatic sync_idle;
`ifdef REFRESH_STALL_EN
        int n = 0;
        while (!busy && n < 250) begin @(negedge clk); n++; end
        while (busy && n < 300) begin @(negedge clk); n++; end
        check_eq("refresh_sync", 32'(busy), 32'd0);
`endif
    endtask

    task automatic xact(input logic w, input logic r, input logic [24:0] a,
                        input logic [15:0] d, input int exp_lat, input string tag,
                        output logic [15:0] q);
        int n = 0;
        @(negedge clk);
        we = w; re = r; addr = a; wdata = d;
        @(negedge clk);
        we = 1'b0; re = 1'b0;
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        while (!ack && n < 20) begin @(negedge clk); n++; end
        check_eq({tag, "_lat"}, 32'(n), 32'(exp_lat));
        q = rdata;
        @(negedge clk);
        check_eq({tag, "_ack1cyc"}, 32'(ack), 32'd0);
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] q;
        int acks;
        logic [15:0] qd;

        rst_n = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_ack", 32'(ack), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_data", 32'(rdata), 32'd0);
        rst_n = 1'b1;
        sync_idle();

        // Basic write then read-back
        xact(1'b1, 1'b0, 25'd5, 16'h1234, 2, "wr5", q);
        xact(1'b0, 1'b1, 25'd5, 16'h0000, 4, "rd5", q);
        check_eq("rd5_data", 32'(q), 32'h1234);

        // Request raised while busy is ignored
        xact(1'b1, 1'b0, 25'd6, 16'h6666, 2, "wr6", q);
        @(negedge clk); re = 1'b1; addr = 25'd6;
        @(negedge clk); re = 1'b1; addr = 25'd5;
        @(negedge clk); re = 1'b0;
        acks = 0; qd = '0;
        for (int i = 0; i < 12; i++) begin
            if (ack) begin acks++; qd = rdata; end
            @(negedge clk);
        end
        check_eq("busy_ign_acks", 32'(acks), 32'd1);
        check_eq("busy_ign_data", 32'(qd), 32'h6666);

        // Write and read together: write wins, data_o untouched
        sync_idle();
        xact(1'b1, 1'b1, 25'd7, 16'hBEEF, 2, "wrrd7", q);
        check_eq("wrrd7_dout_hold", 32'(q), 32'h6666);
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            if (ack) acks++;
            @(negedge clk);
        end
        check_eq("wrrd7_no2nd", 32'(acks), 32'd0);
        xact(1'b0, 1'b1, 25'd7, 16'h0000, 4, "rd7", q);
        check_eq("rd7_data", 32'(q), 32'hBEEF);

        // Address aliasing modulo depth
        sync_idle();
        xact(1'b1, 1'b0, 25'd1029, 16'h00AA, 2, "wr1029", q);
        xact(1'b0, 1'b1, 25'd5, 16'h0000, 4, "rd5_alias", q);
        check_eq("alias_data", 32'(q), 32'h00AA);

        // Reset two edges into a read
        sync_idle();
        @(negedge clk); re = 1'b1; addr = 25'd5;
        @(negedge clk); re = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_data", 32'(rdata), 32'd0);
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            if (ack) acks++;
            @(negedge clk);
        end
        check_eq("midrst_noack", 32'(acks), 32'd0);
        xact(1'b0, 1'b1, 25'd5, 16'h0000, 4, "rd5_postrst", q);
        check_eq("postrst_data", 32'(q), 32'h00AA);

`ifdef REFRESH_STALL_EN
        begin
            int  rise1 = -1;
            int  rise2 = -1;
            int  len = 0;
            int  n = 0;
            int  k;
            logic prev = 1'b0;
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            for (int i = 0; i < 250; i++) begin
                @(negedge clk);
                if (busy && !prev) begin
                    if (rise1 < 0) rise1 = i;
                    else if (rise2 < 0) rise2 = i;
                end
                if (busy && rise2 < 0) len++;
                prev = busy;
            end
            check_eq("ref_first", 32'(rise1), 32'd100);
            check_eq("ref_period", 32'(rise2 - rise1), 32'd100);
            check_eq("ref_len", 32'(len), 32'd8);
            k = rise2 + 98 - 249;
            if (rise2 >= 0 && k >= 0) begin
                repeat (k) @(negedge clk);
                re = 1'b1; addr = 25'd5;
                @(negedge clk);
                re = 1'b0;
                while (!ack && n < 20) begin @(negedge clk); n++; end
                check_eq("ref_rd_lat", 32'(n), 32'd4);
                check_eq("ref_rd_data", 32'(rdata), 32'h00AA);
                n = 0;
                @(negedge clk);
                while (busy && n < 20) begin @(negedge clk); n++; end
                check_eq("ref_after_ack", 32'(n), 32'd8);
            end
        end
`else
        begin
            int nb = 0;
            for (int i = 0; i < 150; i++) begin
                @(negedge clk);
                if (busy) nb++;
            end
            check_eq("idle_never_busy", 32'(nb), 32'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
